// File: rtl/stereo_disparity_search.sv
// ---------------------------------------------------------------------------
// StereoDisparitySearch
//
// Purpose:
//   Sweeps disparities d = 0..MAX_DISP over a WIN-pixel sum-of-absolute-
//   differences window. It reads the left and right calc-line RAMs, which
//   have a one-cycle read latency. It reports the disparity with the smallest
//   SAD ("move"), that SAD, and a flag set when no disparity was usable for
//   the latched reference column.
//
// Ports:
//   clk      - calc clock (sysclk)
//   rst_n    - asynchronous active-low reset
//   start    - begin a search, honoured only while idle
//   ref_col  - left-line start column of the window, latched at start
//   addr_l   - left RAM read address
//   addr_r   - right RAM read address
//   rden     - read enable to both RAMs
//   data_l   - left RAM data, valid one cycle after its address
//   data_r   - right RAM data, valid one cycle after its address
//   busy     - search in progress
//   done     - one-cycle pulse marking freshly updated results
//   disp     - best disparity, held until the next done
//   min_sad  - SAD of the best disparity, held
//   nomatch  - no disparity was valid for ref_col, held
// ---------------------------------------------------------------------------
module stereo_disparity_search #(
    parameter int PIX_W    = 3,
    parameter int ADDR_W   = 11,
    parameter int WIN      = 16,
    parameter int MAX_DISP = 63,
    parameter int DISP_W   = 6,
    parameter int SAD_W    = PIX_W + $clog2(WIN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] ref_col,
    output logic [ADDR_W-1:0] addr_l,
    output logic [ADDR_W-1:0] addr_r,
    output logic              rden,
    input  logic [PIX_W-1:0]  data_l,
    input  logic [PIX_W-1:0]  data_r,
    output logic              busy,
    output logic              done,
    output logic [DISP_W-1:0] disp,
    output logic [SAD_W-1:0]  min_sad,
    output logic              nomatch
);

    localparam int CNT_W = $clog2(WIN + 1);
    localparam logic [CNT_W-1:0]  C_LAST  = CNT_W'(WIN);
    localparam logic [DISP_W-1:0] D_LAST  = DISP_W'(MAX_DISP);
    localparam logic [SAD_W-1:0]  SAD_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CMP,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  refCol_q, refCol_d;
    logic [DISP_W-1:0]  dispIdx_q, dispIdx_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [SAD_W-1:0]   acc_q, acc_d;
    logic [SAD_W-1:0]   bestSad_q, bestSad_d;
    logic [DISP_W-1:0]  bestDisp_q, bestDisp_d;
    logic               found_q, found_d;
    logic               done_q, done_d;
    logic [DISP_W-1:0]  disp_q, disp_d;
    logic [SAD_W-1:0]   minSad_q, minSad_d;
    logic               nomatch_q, nomatch_d;

    logic [PIX_W-1:0]   pixDiff;
    logic [ADDR_W-1:0]  cycleExt;
    logic [ADDR_W-1:0]  dispExt;
    logic               candValid;

    // Absolute pixel difference, plus the widened counter and disparity used
    // for address arithmetic. A disparity is valid only if the right-line
    // column ref_col - d does not go below zero. Both operands are widened so
    // the comparison is safe for any ADDR_W/DISP_W combination.
    always_comb begin
        pixDiff   = (data_l >= data_r) ? (data_l - data_r) : (data_r - data_l);
        cycleExt  = ADDR_W'(cycle_q);
        dispExt   = ADDR_W'(dispIdx_q);
        candValid = ({{DISP_W{1'b0}}, refCol_q} >= {{ADDR_W{1'b0}}, dispIdx_q});
    end

    // State register and all datapath registers. Reset clears the held
    // results and sets min_sad to all-ones. Any search in flight is dropped
    // without producing a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            refCol_q   <= '0;
            dispIdx_q  <= '0;
            cycle_q    <= '0;
            acc_q      <= '0;
            bestSad_q  <= SAD_MAX;
            bestDisp_q <= '0;
            found_q    <= 1'b0;
            done_q     <= 1'b0;
            disp_q     <= '0;
            minSad_q   <= SAD_MAX;
            nomatch_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            refCol_q   <= refCol_d;
            dispIdx_q  <= dispIdx_d;
            cycle_q    <= cycle_d;
            acc_q      <= acc_d;
            bestSad_q  <= bestSad_d;
            bestDisp_q <= bestDisp_d;
            found_q    <= found_d;
            done_q     <= done_d;
            disp_q     <= disp_d;
            minSad_q   <= minSad_d;
            nomatch_q  <= nomatch_d;
        end
    end

    // Next-state and output logic. Each disparity costs WIN+1 RUN cycles:
    // WIN issue cycles, then one drain cycle that collects the last RAM word.
    // One CMP cycle follows. The accumulator clears on the first issue cycle,
    // because the data arriving then belongs to the previous request.
    always_comb begin
        state_d    = state_q;
        refCol_d   = refCol_q;
        dispIdx_d  = dispIdx_q;
        cycle_d    = cycle_q;
        acc_d      = acc_q;
        bestSad_d  = bestSad_q;
        bestDisp_d = bestDisp_q;
        found_d    = found_q;
        done_d     = 1'b0;
        disp_d     = disp_q;
        minSad_d   = minSad_q;
        nomatch_d  = nomatch_q;
        rden       = 1'b0;
        addr_l     = '0;
        addr_r     = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    refCol_d   = ref_col;
                    dispIdx_d  = '0;
                    cycle_d    = '0;
                    bestSad_d  = SAD_MAX;
                    bestDisp_d = '0;
                    found_d    = 1'b0;
                    state_d    = RUN;
                end
            end

            RUN: begin
                if (cycle_q != C_LAST) begin
                    rden   = 1'b1;
                    addr_l = refCol_q + cycleExt;
                    addr_r = refCol_q + cycleExt - dispExt;
                end
                if (cycle_q == '0) begin
                    acc_d = '0;
                end else begin
                    acc_d = acc_q + SAD_W'(pixDiff);
                end
                if (cycle_q == C_LAST) begin
                    cycle_d = '0;
                    state_d = CMP;
                end else begin
                    cycle_d = cycle_q + CNT_W'(1);
                end
            end

            CMP: begin
                // The compare is strict, so on a tie the earlier (smaller)
                // disparity is kept.
                if (candValid) begin
                    found_d = 1'b1;
                    if (acc_q < bestSad_q) begin
                        bestSad_d  = acc_q;
                        bestDisp_d = dispIdx_q;
                    end
                end
                if (dispIdx_q == D_LAST) begin
                    state_d = DONE;
                end else begin
                    dispIdx_d = dispIdx_q + DISP_W'(1);
                    state_d   = RUN;
                end
            end

            DONE: begin
                done_d    = 1'b1;
                disp_d    = found_q ? bestDisp_q : '0;
                minSad_d  = found_q ? bestSad_q : SAD_MAX;
                nomatch_d = ~found_q;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered results are presented directly. busy covers the whole
    // RUN/CMP/DONE span.
    always_comb begin
        busy    = (state_q != IDLE);
        done    = done_q;
        disp    = disp_q;
        min_sad = minSad_q;
        nomatch = nomatch_q;
    end

endmodule

// File: tb/tb_stereo_disparity_search.sv
// ---------------------------------------------------------------------------
// TbStereoDisparitySearch
//
// Purpose:
//   Directed bench for stereo_disparity_search with default parameters.
//   Behavioural left and right calc-line RAMs give one-cycle read latency.
//   Each scenario task drives a search and compares results against values
//   worked out by hand from the line contents.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_stereo_disparity_search;

    localparam int LATENCY = 1153;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        start   = 1'b0;
    logic [10:0] ref_col = '0;
    logic [10:0] addr_l;
    logic [10:0] addr_r;
    logic        rden;
    logic [2:0]  data_l;
    logic [2:0]  data_r;
    logic        busy;
    logic        done;
    logic [5:0]  disp;
    logic [6:0]  min_sad;
    logic        nomatch;

    logic [2:0]  lmem [0:2047];
    logic [2:0]  rmem [0:2047];

    int vectors     = 0;
    int miscompares = 0;

    int obsDoneCycle;
    int obsAddrBad;
    int obsStableBad;

    stereo_disparity_search dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ref_col (ref_col),
        .addr_l  (addr_l),
        .addr_r  (addr_r),
        .rden    (rden),
        .data_l  (data_l),
        .data_r  (data_r),
        .busy    (busy),
        .done    (done),
        .disp    (disp),
        .min_sad (min_sad),
        .nomatch (nomatch)
    );

    // Free-running calc clock.
    always #5 clk = ~clk;

    // Calc-line RAM models: registered read, data valid one cycle after the
    // address.
    always @(posedge clk) begin
        if (rden) begin
            data_l <= lmem[addr_l];
            data_r <= rmem[addr_r];
        end
    end

    // Line fill helpers.
    task automatic fillIdentical();
        for (int i = 0; i < 2048; i++) begin
            lmem[i] = 3'(i % 8);
            rmem[i] = 3'(i % 8);
        end
    endtask

    task automatic fillShift(input int shift);
        for (int i = 0; i < 2048; i++) lmem[i] = 3'($urandom_range(0, 7));
        for (int i = 0; i < 2048; i++) rmem[i] = lmem[(i + shift) % 2048];
    endtask

    task automatic fillConst(input logic [2:0] lv, input logic [2:0] rv);
        for (int i = 0; i < 2048; i++) begin
            lmem[i] = lv;
            rmem[i] = rv;
        end
    endtask

    // Starts a search from a negedge and follows it one cycle at a time until
    // done. Along the way it counts address/rden/busy deviations and any
    // change to the held results before done. It returns on the negedge where
    // done is seen, or after a bounded number of cycles.
    task automatic runSearch(input logic [10:0] refCol, input int extraStartAt);
        logic [5:0]  d0;
        logic [6:0]  s0;
        logic        n0;
        logic [10:0] expL;
        logic [10:0] expR;
        int          idx;
        int          dd;
        int          cc;
        d0 = disp;
        s0 = min_sad;
        n0 = nomatch;
        obsDoneCycle = -1;
        obsAddrBad   = 0;
        obsStableBad = 0;
        start   = 1'b1;
        ref_col = refCol;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 1300; k++) begin
            if (done === 1'b1) begin
                obsDoneCycle = k - 1;
                break;
            end
            if (disp !== d0 || min_sad !== s0 || nomatch !== n0) obsStableBad++;
            if (busy !== 1'b1) obsAddrBad++;
            if (k <= 1152) begin
                idx = k - 1;
                dd  = idx / 18;
                cc  = idx % 18;
                if (cc < 16) begin
                    expL = refCol + 11'(cc);
                    expR = refCol + 11'(cc) - 11'(dd);
                    if (rden !== 1'b1 || addr_l !== expL || addr_r !== expR) obsAddrBad++;
                end else if (rden !== 1'b0) begin
                    obsAddrBad++;
                end
            end else if (rden !== 1'b0) begin
                obsAddrBad++;
            end
            start = (k == extraStartAt);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Asynchronous reset from idle.
    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (disp !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_disp: got %0d expected 0", disp);
        end
        vectors++;
        if (min_sad !== 7'd127) begin
            miscompares++;
            $display("[TB] FAIL reset_min_sad: got %0d expected 127", min_sad);
        end
        vectors++;
        if ({nomatch, done, busy, rden} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {nomatch, done, busy, rden});
        end
        vectors++;
        if (addr_l !== 11'd0 || addr_r !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_addr: got %0d/%0d expected 0/0", addr_l, addr_r);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Identical lines: every window matches at d=0.
    task automatic test_identical();
        fillIdentical();
        runSearch(11'd100, 0);
        vectors++;
        if (obsDoneCycle !== LATENCY) begin
            miscompares++;
            $display("[TB] FAIL ident_latency: got %0d expected %0d", obsDoneCycle, LATENCY);
        end
        vectors++;
        if (obsAddrBad !== 0) begin
            miscompares++;
            $display("[TB] FAIL ident_addr_seq: got %0d bad cycles expected 0", obsAddrBad);
        end
        vectors++;
        if (disp !== 6'd0 || min_sad !== 7'd0 || nomatch !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ident_result: got disp=%0d sad=%0d nm=%b expected 0/0/0", disp, min_sad, nomatch);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ident_busy_at_done: got %b expected 0", busy);
        end
    endtask

    // R[x] = L[x+5] with random content: the best match is at d=5.
    task automatic test_shift();
        fillShift(5);
        runSearch(11'd200, 0);
        vectors++;
        if (disp !== 6'd5 || min_sad !== 7'd0) begin
            miscompares++;
            $display("[TB] FAIL shift_result: got disp=%0d sad=%0d expected 5/0", disp, min_sad);
        end
        vectors++;
        if (obsStableBad !== 0) begin
            miscompares++;
            $display("[TB] FAIL shift_hold: got %0d early changes expected 0", obsStableBad);
        end
        vectors++;
        if (obsDoneCycle !== LATENCY || obsAddrBad !== 0) begin
            miscompares++;
            $display("[TB] FAIL shift_timing: got latency=%0d bad=%0d expected %0d/0", obsDoneCycle, obsAddrBad, LATENCY);
        end
    endtask

    // Flat lines: all SADs tie at 0 and the smallest d wins. Then L=7, R=0
    // gives SAD 16*7 = 112 everywhere.
    task automatic test_constant();
        fillConst(3'd3, 3'd3);
        runSearch(11'd100, 0);
        vectors++;
        if (disp !== 6'd0 || min_sad !== 7'd0) begin
            miscompares++;
            $display("[TB] FAIL const_tie: got disp=%0d sad=%0d expected 0/0", disp, min_sad);
        end
        fillConst(3'd7, 3'd0);
        runSearch(11'd100, 0);
        vectors++;
        if (disp !== 6'd0 || min_sad !== 7'd112 || nomatch !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL const_max_sad: got disp=%0d sad=%0d nm=%b expected 0/112/0", disp, min_sad, nomatch);
        end
    endtask

    // ref_col=3: only d=0..3 may win. The true shift of 2 must be found,
    // and the right address must follow ref_col+c-d.
    task automatic test_small_ref();
        fillShift(2);
        runSearch(11'd3, 0);
        vectors++;
        if (disp !== 6'd2 || min_sad !== 7'd0) begin
            miscompares++;
            $display("[TB] FAIL smallref_result: got disp=%0d sad=%0d expected 2/0", disp, min_sad);
        end
        vectors++;
        if (disp > 6'd3) begin
            miscompares++;
            $display("[TB] FAIL smallref_bound: got disp=%0d expected <=3", disp);
        end
        vectors++;
        if (obsAddrBad !== 0) begin
            miscompares++;
            $display("[TB] FAIL smallref_addr_seq: got %0d bad cycles expected 0", obsAddrBad);
        end
    endtask

    // A start pulse mid-search is ignored. A start in the idle cycle right
    // after done launches a second search at once.
    task automatic test_back_to_back();
        fillShift(5);
        runSearch(11'd200, 500);
        vectors++;
        if (obsDoneCycle !== LATENCY || disp !== 6'd5) begin
            miscompares++;
            $display("[TB] FAIL b2b_first: got latency=%0d disp=%0d expected %0d/5", obsDoneCycle, disp, LATENCY);
        end
        runSearch(11'd300, 0);
        vectors++;
        if (obsDoneCycle !== LATENCY || obsAddrBad !== 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_timing: got latency=%0d bad=%0d expected %0d/0", obsDoneCycle, obsAddrBad, LATENCY);
        end
        vectors++;
        if (disp !== 6'd5 || min_sad !== 7'd0) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_result: got disp=%0d sad=%0d expected 5/0", disp, min_sad);
        end
    endtask

    // Reset partway through a search clears the outputs immediately and
    // produces no done. A fresh search afterwards completes normally.
    task automatic test_reset_midsearch();
        int doneSeen;
        doneSeen = 0;
        start   = 1'b1;
        ref_col = 11'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (699) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (disp !== 6'd0 || min_sad !== 7'd127 || nomatch !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_result: got disp=%0d sad=%0d nm=%b expected 0/127/0", disp, min_sad, nomatch);
        end
        vectors++;
        if ({busy, rden, done} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL midrst_flags: got %b expected 000", {busy, rden, done});
        end
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0) doneSeen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) doneSeen++;
        end
        vectors++;
        if (doneSeen !== 0) begin
            miscompares++;
            $display("[TB] FAIL midrst_no_done: got %0d done cycles expected 0", doneSeen);
        end
        runSearch(11'd200, 0);
        vectors++;
        if (obsDoneCycle !== LATENCY || disp !== 6'd5 || min_sad !== 7'd0) begin
            miscompares++;
            $display("[TB] FAIL midrst_recover: got latency=%0d disp=%0d sad=%0d expected %0d/5/0", obsDoneCycle, disp, min_sad, LATENCY);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        $display("[TB] starting stereo_disparity_search bench");
        test_reset();
        test_identical();
        test_shift();
        test_constant();
        test_small_ref();
        test_back_to_back();
        test_reset_midsearch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
